// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_pkg
//  Description : Shared constants, types and the colour-expansion helper for
//                the frame-buffer arbiter.
//                The frame buffer is RGB332 at 400x225, which is a 4x
//                downscale of the 1600x900 display raster.
//  Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

  localparam int FB_W     = 400;   // frame-buffer width in pixels
  localparam int FB_H     = 225;   // frame-buffer height in pixels
  localparam int SCALE_SH = 2;     // screen-to-buffer downscale shift
  localparam int ADDR_W   = 17;    // SRAM address width (FB_W*FB_H <= 2**ADDR_W)
  localparam int DATA_W   = 8;     // SRAM word width (RGB332)
  localparam int SCREEN_W = 1600;  // visible screen width
  localparam int SCREEN_H = 900;   // visible screen height

  // One frame-buffer word.
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  // What a display slot turns into two cycles later.
  typedef enum logic [1:0] {
    SLOT_READ  = 2'd0,  // colour comes from the SRAM read port
    SLOT_HIT   = 2'd1,  // colour comes from the held copy of the last read
    SLOT_BLACK = 2'd2   // off-screen position: black
  } slot_kind_e;

  // Replicate the MSBs so that full-scale RGB332 maps to full-scale RGB888.
  function automatic logic [23:0] rgb332_to_rgb888(input rgb332_t c);
    return {c.r, c.r, c.r[2:1], c.g, c.g, c.g[2:1], c.b, c.b, c.b, c.b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : fb_rr_arb2
//  Description : Two-requester round-robin arbiter.
//                It issues a grant only while i_en is high. When both
//                requesters are active, the pointer selects the winner.
//                The pointer moves past the granted requester, so it only
//                changes when a grant is given.
//  Ports       : i_clk, i_rst  - clock, synchronous active-high reset
//                i_en          - arbitration allowed this cycle
//                i_req[1:0]    - request per requester
//                o_gnt[1:0]    - one-hot grant (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // 0: requester 0 has priority on a tie, 1: requester 1 has priority
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    o_gnt = 2'b00;
    ptr_d = ptr_q;
    if (i_en) begin
      if (i_req == 2'b11) begin
        o_gnt = ptr_q ? 2'b10 : 2'b01;
      end else begin
        o_gnt = i_req;
      end
    end
    if (o_gnt[0]) begin
      ptr_d = 1'b1;
    end else if (o_gnt[1]) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fb_arbiter
//  Description : Shares a single-port synchronous frame-buffer SRAM between
//                the display fetch and two game-logic writers.
//                The display has absolute priority. If a display request
//                reads the same word as the previous read, the SRAM slot is
//                given to the writers instead. Each fetched RGB332 word is
//                expanded to 24-bit colour with a fixed two-cycle latency.
//  Ports       : i_clk, i_rst                 - clock, sync active-high reset
//                i_pos_valid, i_H_pos, i_V_pos - display fetch position
//                o_color, o_color_valid        - expanded colour to VGA
//                i_wN_valid/addr/data, o_wN_ready - writer handshakes (N=0,1)
//                o_mem_en/we/addr/wdata, i_mem_rdata - SRAM interface
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_arbiter
  import fb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pos_valid,
  input  logic [10:0]       i_H_pos,
  input  logic [9:0]        i_V_pos,
  output logic [23:0]       o_color,
  output logic              o_color_valid,
  input  logic              i_w0_valid,
  input  logic [ADDR_W-1:0] i_w0_addr,
  input  logic [DATA_W-1:0] i_w0_data,
  output logic              o_w0_ready,
  input  logic              i_w1_valid,
  input  logic [ADDR_W-1:0] i_w1_addr,
  input  logic [DATA_W-1:0] i_w1_data,
  output logic              o_w1_ready,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  logic [ADDR_W-1:0] fa;
  logic              in_range;
  logic              hit;
  logic              disp_read;
  logic              arb_en;
  logic [1:0]        gnt;

  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cache_valid_q, cache_valid_d;
  logic [ADDR_W-1:0] cache_addr_q,  cache_addr_d;
  logic              s1_valid_q, s1_valid_d;
  slot_kind_e        s1_kind_q,  s1_kind_d;
  logic              s2_valid_q, s2_valid_d;
  slot_kind_e        s2_kind_q,  s2_kind_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [23:0]       color_q, color_d;
  logic              color_valid_q, color_valid_d;

  // Display request decode. The address wraps by truncation to ADDR_W.
  always_comb begin
    fa = ADDR_W'(i_V_pos >> SCALE_SH) * ADDR_W'(FB_W) + ADDR_W'(i_H_pos >> SCALE_SH);
    in_range  = (i_H_pos < 11'(SCREEN_W)) && (i_V_pos < 10'(SCREEN_H));
    hit       = cache_valid_q && (fa == cache_addr_q);
    disp_read = i_pos_valid && in_range && !hit && !i_rst;
    // Writers use every cycle the display does not need, including hit
    // slots, off-screen slots and blanking.
    arb_en    = !disp_read && !i_rst;
  end

  fb_rr_arb2 u_rr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (arb_en),
    .i_req ({i_w1_valid, i_w0_valid}),
    .o_gnt (gnt)
  );

  assign o_w0_ready = gnt[0];
  assign o_w1_ready = gnt[1];

  always_comb begin
    mem_en_d    = disp_read || (gnt != 2'b00);
    mem_we_d    = (gnt != 2'b00);
    mem_addr_d  = disp_read ? fa : (gnt[1] ? i_w1_addr : i_w0_addr);
    mem_wdata_d = gnt[1] ? i_w1_data : i_w0_data;

    // A display read and a write are never in the same cycle. Therefore a
    // load of a new cached address and an invalidation cannot conflict.
    cache_valid_d = cache_valid_q;
    cache_addr_d  = cache_addr_q;
    if (disp_read) begin
      cache_valid_d = 1'b1;
      cache_addr_d  = fa;
    end else if ((gnt[0] && (i_w0_addr == cache_addr_q)) ||
                 (gnt[1] && (i_w1_addr == cache_addr_q))) begin
      cache_valid_d = 1'b0;
    end

    // Two-stage slot pipeline. Its length matches the SRAM read latency,
    // so every slot kind leaves the pipeline exactly two edges after it
    // was sampled.
    s1_valid_d = i_pos_valid;
    s1_kind_d  = !in_range ? SLOT_BLACK : (hit ? SLOT_HIT : SLOT_READ);
    s2_valid_d = s1_valid_q;
    s2_kind_d  = s1_kind_q;

    color_valid_d = s2_valid_q;
    color_d       = 24'h0;
    data_d        = data_q;
    if (s2_valid_q) begin
      case (s2_kind_q)
        SLOT_READ: begin
          color_d = rgb332_to_rgb888(rgb332_t'(i_mem_rdata));
          data_d  = i_mem_rdata;
        end
        SLOT_HIT:  color_d = rgb332_to_rgb888(rgb332_t'(data_q));
        default:   color_d = 24'h0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      cache_valid_q <= 1'b0;
      cache_addr_q  <= '0;
      s1_valid_q    <= 1'b0;
      s1_kind_q     <= SLOT_READ;
      s2_valid_q    <= 1'b0;
      s2_kind_q     <= SLOT_READ;
      data_q        <= '0;
      color_q       <= 24'h0;
      color_valid_q <= 1'b0;
    end else begin
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      cache_valid_q <= cache_valid_d;
      cache_addr_q  <= cache_addr_d;
      s1_valid_q    <= s1_valid_d;
      s1_kind_q     <= s1_kind_d;
      s2_valid_q    <= s2_valid_d;
      s2_kind_q     <= s2_kind_d;
      data_q        <= data_d;
      color_q       <= color_d;
      color_valid_q <= color_valid_d;
    end
  end

  assign o_mem_en      = mem_en_q;
  assign o_mem_we      = mem_we_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_mem_wdata   = mem_wdata_q;
  assign o_color       = color_q;
  assign o_color_valid = color_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_arbiter
//  Description : Self-checking bench for fb_arbiter. It contains a behavioural
//                SRAM and a reference model of the sharing rules: a memory
//                image, the last-read address, and the round-robin turn.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pos_valid;
  logic [10:0] h_pos;
  logic [9:0]  v_pos;
  logic [23:0] color;
  logic        color_valid;
  logic        w0_valid, w1_valid;
  logic [16:0] w0_addr, w1_addr;
  logic [7:0]  w0_data, w1_data;
  logic        w0_ready, w1_ready;
  logic        mem_en, mem_we;
  logic [16:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  fb_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_pos_valid(pos_valid), .i_H_pos(h_pos), .i_V_pos(v_pos),
    .o_color(color), .o_color_valid(color_valid),
    .i_w0_valid(w0_valid), .i_w0_addr(w0_addr), .i_w0_data(w0_data), .o_w0_ready(w0_ready),
    .i_w1_valid(w1_valid), .i_w1_addr(w1_addr), .i_w1_data(w1_data), .o_w1_ready(w1_ready),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_word(input int a);
    if (a == 0) return 8'hE0;
    return 8'(((a * 37) + 11) ^ (a >> 3));
  endfunction

  function automatic logic [23:0] expand(input logic [7:0] w);
    int r, g, b;
    r = int'(w[7:5]);
    g = int'(w[4:2]);
    b = int'(w[1:0]);
    return {8'((r << 5) | (r << 2) | (r >> 1)), 8'((g << 5) | (g << 2) | (g >> 1)), 8'(b * 85)};
  endfunction

  // Behavioural SRAM. It fills itself on the first edge and returns junk
  // on cycles without a read.
  logic [7:0] tb_mem [0:131071];
  bit         mem_ready_flag = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready_flag) begin
      for (int a = 0; a < 131072; a++) tb_mem[a] <= init_word(a);
      mem_ready_flag <= 1'b1;
      mem_rdata <= 8'h00;
    end else if (mem_en && mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
      mem_rdata <= 8'($urandom);
    end else if (mem_en) begin
      mem_rdata <= tb_mem[mem_addr];
    end else begin
      mem_rdata <= 8'($urandom);
    end
  end

  // Reference model state
  logic [7:0]  ref_mem [0:131071];
  bit          m_cv;
  int          m_ca;
  int          m_turn;        // writer that wins a tie
  logic [24:0] pipe[$];       // {valid, colour} per sampled slot
  // Expectations and observations for the edge just taken
  logic        obs_r0, obs_r1, exp_r0, exp_r1;
  logic        exp_en, exp_we, exp_cv;
  logic [16:0] exp_addr;
  logic [7:0]  exp_wdata;
  logic [23:0] exp_col;

  // Samples the readies, computes what the edge must produce from the
  // sharing rules, advances the model, then takes the edge.
  task automatic tick();
    int fa;
    bit inr, hit, rd, g0, g1;
    logic [24:0] e;
    #1;
    obs_r0 = w0_ready;
    obs_r1 = w1_ready;
    fa  = ((int'(v_pos) / 4) * 400 + int'(h_pos) / 4) % 131072;
    inr = (int'(h_pos) < 1600) && (int'(v_pos) < 900);
    if (rst) begin
      exp_r0 = 0; exp_r1 = 0; exp_en = 0; exp_we = 0; exp_addr = 0; exp_wdata = 0;
      exp_col = 0; exp_cv = 0;
      m_cv = 0; m_turn = 0;
      pipe.delete();
      pipe.push_back(25'd0);
      pipe.push_back(25'd0);
    end else begin
      hit = pos_valid && inr && m_cv && (fa == m_ca);
      rd  = pos_valid && inr && !hit;
      g0 = 0; g1 = 0;
      if (!rd) begin
        if (w0_valid && w1_valid) begin
          if (m_turn == 0) g0 = 1; else g1 = 1;
        end else begin
          g0 = w0_valid;
          g1 = w1_valid;
        end
      end
      exp_r0 = g0; exp_r1 = g1;
      exp_en = rd || g0 || g1;
      exp_we = g0 || g1;
      exp_addr  = rd ? 17'(fa) : (g0 ? w0_addr : w1_addr);
      exp_wdata = g0 ? w0_data : w1_data;
      e = {pos_valid, (pos_valid && inr) ? expand(ref_mem[fa]) : 24'h0};
      pipe.push_back(e);
      e = pipe.pop_front();
      exp_cv  = e[24];
      exp_col = e[23:0];
      if (rd) begin m_cv = 1; m_ca = fa; end
      if (g0) begin
        ref_mem[w0_addr] = w0_data;
        if (m_cv && int'(w0_addr) == m_ca) m_cv = 0;
        m_turn = 1;
      end
      if (g1) begin
        ref_mem[w1_addr] = w1_data;
        if (m_cv && int'(w1_addr) == m_ca) m_cv = 0;
        m_turn = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; pos_valid = 1; h_pos = 0; v_pos = 0;
    w0_valid = 1; w0_addr = 17'd0; w0_data = 8'h55; w1_valid = 0;
    tick();
    tick();
    n_tests++; if (obs_r0 !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", obs_r0); end
    n_tests++; if (color !== 24'h0) begin n_fail++; $display("FAIL reset_color: got %h expected 0", color); end
    n_tests++; if (color_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cvalid: got %b expected 0", color_valid); end
    n_tests++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", mem_en); end
    n_tests++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", mem_we); end
    n_tests++; if (mem_addr !== 17'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", mem_addr); end
    n_tests++; if (mem_wdata !== 8'd0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", mem_wdata); end
    rst = 0; pos_valid = 0; w0_valid = 0;
  endtask

  task automatic test_writers_rr();
    logic [16:0] want_addr;
    logic [7:0]  want_data;
    pos_valid = 0;
    w0_valid = 1; w0_addr = 17'd5000; w0_data = 8'h10;
    w1_valid = 1; w1_addr = 17'd6000; w1_data = 8'h20;
    for (int i = 0; i < 6; i++) begin
      want_addr = (i % 2 == 0) ? 17'd5000 : 17'd6000;
      want_data = (i % 2 == 0) ? w0_data : w1_data;
      tick();
      n_tests++; if (obs_r0 !== (i % 2 == 0) || obs_r1 !== (i % 2 == 1)) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got r0=%b r1=%b expected r0=%b", i, obs_r0, obs_r1, i % 2 == 0); end
      n_tests++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin
        n_fail++; $display("FAIL rr_write[%0d]: got en=%b we=%b expected 1 1", i, mem_en, mem_we); end
      n_tests++; if (mem_addr !== want_addr || mem_wdata !== want_data) begin
        n_fail++; $display("FAIL rr_addr[%0d]: got %0d/%h expected %0d/%h", i, mem_addr, mem_wdata, want_addr, want_data); end
      if (obs_r0) w0_data = w0_data + 8'd1;
      if (obs_r1) w1_data = w1_data + 8'd1;
    end
    w0_valid = 0; w1_valid = 0;
  endtask

  task automatic test_first_pixel();
    pos_valid = 1; h_pos = 0; v_pos = 0;
    tick();
    n_tests++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'd0) begin
      n_fail++; $display("FAIL first_read: got en=%b we=%b addr=%0d expected 1 0 0", mem_en, mem_we, mem_addr); end
    pos_valid = 0;
    tick();
    tick();
    n_tests++; if (color !== 24'hFF0000 || color_valid !== 1'b1) begin
      n_fail++; $display("FAIL first_color: got %h/%b expected ff0000/1", color, color_valid); end
  endtask

  task automatic test_sweep();
    int reads = 0;
    logic [23:0] want;
    v_pos = 4;
    w0_valid = 1; w0_addr = 17'd2000; w0_data = 8'h77;
    for (int t = 0; t < 10; t++) begin
      pos_valid = (t < 8);
      h_pos = 11'(t < 8 ? t : 0);
      if (t >= 8) w0_valid = 0;
      tick();
      if (t < 8) begin
        n_tests++; if (obs_r0 !== (t % 4 != 0)) begin
          n_fail++; $display("FAIL sweep_ready[%0d]: got %b expected %b", t, obs_r0, t % 4 != 0); end
      end
      if (obs_r0) w0_data = w0_data + 8'd1;
      if (mem_en && !mem_we) begin
        reads++;
        n_tests++; if (mem_addr !== ((t == 0) ? 17'd400 : 17'd401)) begin
          n_fail++; $display("FAIL sweep_raddr[%0d]: got %0d expected %0d", t, mem_addr, (t == 0) ? 400 : 401); end
      end
      if (t >= 2) begin
        want = expand(init_word(400 + (t - 2) / 4));
        n_tests++; if (color !== want || color_valid !== 1'b1) begin
          n_fail++; $display("FAIL sweep_color[%0d]: got %h/%b expected %h/1", t, color, color_valid, want); end
      end
    end
    n_tests++; if (reads != 2) begin n_fail++; $display("FAIL sweep_reads: got %0d expected 2", reads); end
  endtask

  task automatic test_invalidate();
    logic [23:0] old_c;
    old_c = expand(init_word(400));
    v_pos = 4;
    for (int t = 0; t < 6; t++) begin
      pos_valid = (t < 4);
      h_pos = 11'(t < 4 ? t : 0);
      w0_valid = (t == 1); w0_addr = 17'd400; w0_data = 8'h03;
      tick();
      if (t == 1) begin
        n_tests++; if (obs_r0 !== 1'b1) begin n_fail++; $display("FAIL inv_grant: got %b expected 1", obs_r0); end
      end
      if (t == 2) begin
        n_tests++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'd400) begin
          n_fail++; $display("FAIL inv_reread: got en=%b we=%b addr=%0d expected 1 0 400", mem_en, mem_we, mem_addr); end
      end
      if (t >= 2) begin
        n_tests++; if (color !== ((t < 4) ? old_c : 24'h0000FF)) begin
          n_fail++; $display("FAIL inv_color[%0d]: got %h expected %h", t, color, (t < 4) ? old_c : 24'h0000FF); end
      end
    end
    w0_valid = 0;
  endtask

  task automatic test_out_of_range();
    pos_valid = 1; h_pos = 11'd1600; v_pos = 10'd10;
    w1_valid = 1; w1_addr = 17'd7000; w1_data = 8'h5A;
    tick();
    n_tests++; if (obs_r1 !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 17'd7000) begin
      n_fail++; $display("FAIL oor_slot: got r1=%b en=%b we=%b addr=%0d expected 1 1 1 7000", obs_r1, mem_en, mem_we, mem_addr); end
    pos_valid = 0; w1_valid = 0;
    tick();
    tick();
    n_tests++; if (color !== 24'h0 || color_valid !== 1'b1) begin
      n_fail++; $display("FAIL oor_color: got %h/%b expected 0/1", color, color_valid); end
  endtask

  task automatic test_reset_mid();
    pos_valid = 1; h_pos = 11'd40; v_pos = 10'd40;
    tick();
    n_tests++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'd4010) begin
      n_fail++; $display("FAIL rmid_read: got en=%b we=%b addr=%0d expected 1 0 4010", mem_en, mem_we, mem_addr); end
    rst = 1; pos_valid = 0;
    w0_valid = 1; w0_addr = 17'd9000; w0_data = 8'hC3;
    tick();
    n_tests++; if (obs_r0 !== 1'b0) begin n_fail++; $display("FAIL rmid_ready: got %b expected 0", obs_r0); end
    n_tests++; if ({color, color_valid, mem_en, mem_we, mem_addr, mem_wdata} !== 52'd0) begin
      n_fail++; $display("FAIL rmid_outputs: got col=%h v=%b en=%b we=%b a=%0d d=%h expected all 0",
                         color, color_valid, mem_en, mem_we, mem_addr, mem_wdata); end
    rst = 0; w0_valid = 0;
    for (int t = 0; t < 2; t++) begin
      tick();
      n_tests++; if (color_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_flush[%0d]: got %b expected 0", t, color_valid); end
    end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      r = $urandom_range(0, 9);
      if (r < 6) begin
        pos_valid = 1;
        h_pos = (h_pos >= 11'd1599) ? 11'd0 : h_pos + 11'd1;
      end else if (r == 6) begin
        pos_valid = 1; h_pos = 11'($urandom_range(0, 2047)); v_pos = 10'($urandom_range(0, 1023));
      end else if (r == 7) begin
        pos_valid = 1; h_pos = 11'($urandom_range(0, 15)); v_pos = 10'($urandom_range(0, 11));
      end else begin
        pos_valid = 0;
      end
      if (!w0_valid || obs_r0) begin
        w0_valid = ($urandom_range(0, 1) == 1);
        w0_addr  = ($urandom_range(0, 3) == 0) ? 17'($urandom_range(0, 131071))
                                               : 17'($urandom_range(0, 2) * 400 + $urandom_range(0, 3));
        w0_data  = 8'($urandom);
      end
      if (!w1_valid || obs_r1) begin
        w1_valid = ($urandom_range(0, 2) != 0);
        w1_addr  = 17'($urandom_range(0, 2) * 400 + $urandom_range(0, 3));
        w1_data  = 8'($urandom);
      end
      tick();
      n_tests++; if (obs_r0 !== exp_r0 || obs_r1 !== exp_r1) begin
        n_fail++; $display("FAIL rnd_ready[%0d]: got %b%b expected %b%b", c, obs_r1, obs_r0, exp_r1, exp_r0); end
      n_tests++; if (mem_en !== exp_en) begin
        n_fail++; $display("FAIL rnd_en[%0d]: got %b expected %b", c, mem_en, exp_en); end
      if (exp_en) begin
        n_tests++; if (mem_we !== exp_we || mem_addr !== exp_addr) begin
          n_fail++; $display("FAIL rnd_op[%0d]: got we=%b addr=%0d expected we=%b addr=%0d", c, mem_we, mem_addr, exp_we, exp_addr); end
      end
      if (exp_en && exp_we) begin
        n_tests++; if (mem_wdata !== exp_wdata) begin
          n_fail++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", c, mem_wdata, exp_wdata); end
      end
      n_tests++; if (color_valid !== exp_cv || color !== exp_col) begin
        n_fail++; $display("FAIL rnd_color[%0d]: got %h/%b expected %h/%b", c, color, color_valid, exp_col, exp_cv); end
    end
  endtask

  initial begin
    for (int a = 0; a < 131072; a++) ref_mem[a] = init_word(a);
    m_cv = 0; m_ca = 0; m_turn = 0;
    pipe.push_back(25'd0);
    pipe.push_back(25'd0);
    obs_r0 = 0; obs_r1 = 0;
    rst = 1; pos_valid = 0; h_pos = 0; v_pos = 0;
    w0_valid = 0; w0_addr = 0; w0_data = 0;
    w1_valid = 0; w1_addr = 0; w1_data = 0;
    test_reset();
    test_writers_rr();
    test_first_pixel();
    test_sweep();
    test_invalidate();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
